vram_arbiter: RTL and testbench

Single-port video RAM arbiter for the mini VGA peripheral. It shares one synchronous VRAM between the scanout pixel fetcher and the JML-8 CPU bus.
- Scanout fetches have strict priority, so the display never glitches.
- CPU writes are posted into a small FIFO and drained in free cycles.
- It sits between the bus interface, the timing/pixel pipeline and the VRAM macro.

---
 rtl/vram_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_vram_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// vram_arbiter: single-port VRAM arbiter for the mini VGA peripheral.
// Scanout fetches always win; CPU writes are posted into a small FIFO and
// drained in free cycles. CPU reads exist only when VRAM_CPU_READ_EN is
// defined; a pending read waits for the write FIFO to drain so it always
// observes earlier writes.
//
// Owner tag carried with each VRAM operation down a 2-stage pipeline:
//   tag        | meaning
//   TAG_NONE   | no read in flight (idle cycle or write)
//   TAG_FETCH  | scanout read, returns on fetch_data/fetch_valid
//   TAG_CPU_RD | CPU read, returns on cpu_rdata/cpu_rvalid (VRAM_CPU_READ_EN)
module vram_arbiter #(
  parameter int ADDR_W     = 13,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [DATA_W-1:0] fetch_data,
  output logic              fetch_valid,
  input  logic              cpu_wr,
  input  logic              cpu_rd,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  output logic              cpu_busy,
  output logic              overflow,
  output logic              starve,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = FIFO_DEPTH[PTR_W:0];

  localparam logic [1:0] TAG_NONE  = 2'd0;
  localparam logic [1:0] TAG_FETCH = 2'd1;

  logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;

  logic              read_pending;
  logic [ADDR_W-1:0] rd_addr;
  logic              issue_rd;
  logic [1:0]        issue_tag;
  logic [1:0]        tag_s1;
  logic [1:0]        tag_s2;
  logic [7:0]        starve_cnt;
  logic              cpu_work;

  assign fifo_full  = (count == FULL_CNT);
  assign fifo_empty = (count == '0);
  // A full FIFO refuses the push even when a pop frees a slot this cycle.
  assign push       = cpu_wr && !fifo_full;
  assign pop        = !fetch_req && !issue_rd && !fifo_empty;
  assign cpu_work   = !fifo_empty || read_pending;

  assign cpu_busy   = fifo_full | read_pending;
  assign starve     = (starve_cnt == 8'hFF);
  assign fetch_data = mem_rdata;

  // Posted-write storage; contents need no reset, pointers guard validity.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= cpu_addr;
      fifo_data[wr_ptr] <= cpu_wdata;
    end
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + (PTR_W+1)'(1);
      else if (pop && !push) count <= count - (PTR_W+1)'(1);
      if (cpu_wr && fifo_full) overflow <= 1'b1;
    end
  end

`ifdef VRAM_CPU_READ_EN
  localparam logic [1:0] TAG_CPU_RD = 2'd2;

  logic rd_done;

  assign issue_rd  = !fetch_req && read_pending && fifo_empty;
  assign issue_tag = fetch_req ? TAG_FETCH : (issue_rd ? TAG_CPU_RD : TAG_NONE);

  // Hold one outstanding CPU read; further strobes are ignored until it issues.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      read_pending <= 1'b0;
      rd_addr      <= '0;
    end else if (issue_rd) begin
      read_pending <= 1'b0;
    end else if (cpu_rd && !read_pending) begin
      read_pending <= 1'b1;
      rd_addr      <= cpu_addr;
    end
  end

  // Return CPU read data one cycle after the matching fetch_valid slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_done    <= 1'b0;
      cpu_rvalid <= 1'b0;
      cpu_rdata  <= '0;
    end else begin
      rd_done    <= (tag_s2 == TAG_CPU_RD);
      cpu_rvalid <= rd_done;
      if (rd_done) cpu_rdata <= mem_rdata;
    end
  end
`else
  logic unused_cpu_rd;

  assign unused_cpu_rd = cpu_rd;
  assign read_pending  = 1'b0;
  assign rd_addr       = '0;
  assign issue_rd      = 1'b0;
  assign issue_tag     = fetch_req ? TAG_FETCH : TAG_NONE;
  assign cpu_rdata     = '0;
  assign cpu_rvalid    = 1'b0;
`endif

  // One VRAM operation per cycle: fetch, then CPU read, then FIFO drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
    end else if (fetch_req) begin
      mem_addr  <= fetch_addr;
      mem_we    <= 1'b0;
    end else if (issue_rd) begin
      mem_addr  <= rd_addr;
      mem_we    <= 1'b0;
    end else if (pop) begin
      mem_addr  <= fifo_addr[rd_ptr];
      mem_wdata <= fifo_data[rd_ptr];
      mem_we    <= 1'b1;
    end else begin
      mem_we    <= 1'b0;
    end
  end

  // Owner tag pipeline; fetch_valid lines up with the VRAM read return.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_s1      <= TAG_NONE;
      tag_s2      <= TAG_NONE;
      fetch_valid <= 1'b0;
    end else begin
      tag_s1      <= issue_tag;
      tag_s2      <= tag_s1;
      fetch_valid <= (tag_s2 == TAG_FETCH);
    end
  end

  // Count cycles that queued CPU work is held off by scanout, saturating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (fetch_req && cpu_work) begin
      if (starve_cnt != 8'hFF) starve_cnt <= starve_cnt + 8'd1;
    end else begin
      starve_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed testbench for vram_arbiter. Inputs change 1 time unit after the
// rising edge and outputs are sampled there too. The VRAM model registers the
// address at its input and the data at its output, so read data for an
// address issued after edge k is visible after edge k+2.
module tb_vram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_req;
  logic [12:0] fetch_addr;
  logic [7:0]  fetch_data;
  logic        fetch_valid;
  logic        cpu_wr;
  logic        cpu_rd;
  logic [12:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_rvalid;
  logic        cpu_busy;
  logic        overflow;
  logic        starve;
  logic [12:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic [7:0]  mem_rdata;

  int checks = 0;
  int passes = 0;

  logic [7:0]  vram [8192];
  logic [12:0] ram_addr_q;

  always #5 clk = ~clk;

  vram_arbiter #(.ADDR_W(13), .DATA_W(8), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fetch_req  (fetch_req),
    .fetch_addr (fetch_addr),
    .fetch_data (fetch_data),
    .fetch_valid(fetch_valid),
    .cpu_wr     (cpu_wr),
    .cpu_rd     (cpu_rd),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_rvalid (cpu_rvalid),
    .cpu_busy   (cpu_busy),
    .overflow   (overflow),
    .starve     (starve),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata)
  );

  always @(posedge clk) begin
    if (mem_we) vram[mem_addr] <= mem_wdata;
    ram_addr_q <= mem_addr;
    mem_rdata  <= vram[ram_addr_q];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) vram[i] = 8'(i);
    rst_n = 1'b0; fetch_req = 1'b0; fetch_addr = '0;
    cpu_wr = 1'b0; cpu_rd = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    step(); step();

    // reset state
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_mem_we", 32'(mem_we), 0);
    check("rst_fetch_valid", 32'(fetch_valid), 0);
    check("rst_cpu_rvalid", 32'(cpu_rvalid), 0);
    check("rst_cpu_rdata", 32'(cpu_rdata), 0);
    check("rst_busy", 32'(cpu_busy), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_starve", 32'(starve), 0);
    rst_n = 1'b1;
    step();

    // fetch latency: 4 back-to-back fetches from 0x100
    fetch_req = 1'b1; fetch_addr = 13'h100;
    for (int i = 0; i < 7; i++) begin
      step();
      if (i == 0) begin
        check("fetch_mem_addr", 32'(mem_addr), 'h100);
        check("fetch_mem_we", 32'(mem_we), 0);
      end
      check("fetch_valid", 32'(fetch_valid), (i >= 2 && i <= 5) ? 1 : 0);
      if (i >= 2 && i <= 5) check("fetch_data", 32'(fetch_data), 32'(i - 2));
      if (i < 3) fetch_addr = 13'(13'h101 + i);
      else fetch_req = 1'b0;
    end

    // contention: writes wait behind continuous fetch
    fetch_req = 1'b1; fetch_addr = 13'h200;
    cpu_wr = 1'b1; cpu_addr = 13'h0010; cpu_wdata = 8'hAA;
    step();
    check("cont_we0", 32'(mem_we), 0);
    cpu_addr = 13'h0011; cpu_wdata = 8'hBB;
    step();
    check("cont_we1", 32'(mem_we), 0);
    cpu_wr = 1'b0;
    step();
    check("cont_we2", 32'(mem_we), 0);
    fetch_req = 1'b0;
    step();
    check("cont_w1_we", 32'(mem_we), 1);
    check("cont_w1_addr", 32'(mem_addr), 'h10);
    check("cont_w1_data", 32'(mem_wdata), 'hAA);
    step();
    check("cont_w2_we", 32'(mem_we), 1);
    check("cont_w2_addr", 32'(mem_addr), 'h11);
    check("cont_w2_data", 32'(mem_wdata), 'hBB);
    step();
    check("cont_idle_we", 32'(mem_we), 0);
    check("cont_idle_addr", 32'(mem_addr), 'h11);
    check("cont_vram", 32'(vram[13'h10]), 'hAA);

    // overflow: 5 writes into a 4-deep FIFO while fetch blocks draining
    fetch_req = 1'b1; fetch_addr = 13'h300;
    cpu_wr = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cpu_addr = 13'(13'h20 + i); cpu_wdata = 8'(8'h30 + i);
      step();
      check("ovf_busy", 32'(cpu_busy), (i >= 3) ? 1 : 0);
      check("ovf_flag", 32'(overflow), (i == 4) ? 1 : 0);
    end
    cpu_wr = 1'b0; fetch_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("ovf_drain_we", 32'(mem_we), 1);
      check("ovf_drain_addr", 32'(mem_addr), 32'(32'h20 + i));
      check("ovf_drain_data", 32'(mem_wdata), 32'(32'h30 + i));
    end
    step();
    check("ovf_end_we", 32'(mem_we), 0);
    check("ovf_end_busy", 32'(cpu_busy), 0);
    check("ovf_sticky", 32'(overflow), 1);
    check("ovf_dropped", 32'(vram[13'h24]), 'h24);

`ifdef VRAM_CPU_READ_EN
    // read-after-write coherence
    fetch_req = 1'b1; fetch_addr = 13'h400;
    cpu_wr = 1'b1; cpu_addr = 13'h1234; cpu_wdata = 8'h5A;
    step();
    cpu_wr = 1'b0; cpu_rd = 1'b1;
    step();
    check("raw_busy_pending", 32'(cpu_busy), 1);
    cpu_rd = 1'b0; fetch_req = 1'b0;
    step();
    check("raw_write_first_we", 32'(mem_we), 1);
    check("raw_write_first_addr", 32'(mem_addr), 'h1234);
    step();
    check("raw_read_we", 32'(mem_we), 0);
    check("raw_read_addr", 32'(mem_addr), 'h1234);
    check("raw_busy_clear", 32'(cpu_busy), 0);
    step();
    check("raw_rvalid_k1", 32'(cpu_rvalid), 0);
    step();
    check("raw_rvalid_k2", 32'(cpu_rvalid), 0);
    step();
    check("raw_rvalid_k3", 32'(cpu_rvalid), 1);
    check("raw_rdata", 32'(cpu_rdata), 'h5A);
    step();
    check("raw_rvalid_pulse", 32'(cpu_rvalid), 0);
    check("raw_rdata_hold", 32'(cpu_rdata), 'h5A);
`else
    // reads disabled: strobe has no effect
    cpu_rd = 1'b1; cpu_addr = 13'h1234;
    step();
    cpu_rd = 1'b0;
    check("nord_busy", 32'(cpu_busy), 0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("nord_rvalid", 32'(cpu_rvalid), 0);
      check("nord_rdata", 32'(cpu_rdata), 0);
    end
`endif

    // starvation: one queued write held off for 300 fetch cycles
    fetch_req = 1'b1; fetch_addr = 13'h500;
    cpu_wr = 1'b1; cpu_addr = 13'h0040; cpu_wdata = 8'h77;
    step();
    cpu_wr = 1'b0;
    repeat (254) step();
    check("starve_pre", 32'(starve), 0);
    step();
    check("starve_set", 32'(starve), 1);
    repeat (44) step();
    check("starve_hold", 32'(starve), 1);
    check("starve_blocked_we", 32'(mem_we), 0);
    fetch_req = 1'b0;
    step();
    check("starve_issue_we", 32'(mem_we), 1);
    check("starve_issue_addr", 32'(mem_addr), 'h40);
    check("starve_clear", 32'(starve), 0);

    // reset mid-stream discards queued work and in-flight reads
    fetch_req = 1'b1; fetch_addr = 13'h600;
    cpu_wr = 1'b1; cpu_addr = 13'h0050; cpu_wdata = 8'h99;
    step();
    cpu_wr = 1'b0; cpu_rd = 1'b1; cpu_addr = 13'h0050;
    step();
    cpu_rd = 1'b0;
    step();
    check("pre_rst_fetch_valid", 32'(fetch_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_fetch_valid", 32'(fetch_valid), 0);
    check("async_rst_mem_addr", 32'(mem_addr), 0);
    check("async_rst_mem_wdata", 32'(mem_wdata), 0);
    check("async_rst_busy", 32'(cpu_busy), 0);
    check("async_rst_overflow", 32'(overflow), 0);
    fetch_req = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check("post_rst_fetch_valid", 32'(fetch_valid), 0);
      check("post_rst_rvalid", 32'(cpu_rvalid), 0);
      check("post_rst_we", 32'(mem_we), 0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
